// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB branch predictor with 2-bit saturating counters.
// Optional perf counters (o_lookups, o_mispredicts) are built when BP_PERF_EN is defined.
module branch_predictor_btb #(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 64,
  parameter logic [1:0]  CNT_INIT = 2'b10,
  parameter int          PERF_W   = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] pc,
  output logic            prediction,
  output logic [XLEN-1:0] PCTargetF,
  input  logic            i_upd_vld,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_is_jump,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_pred,
  input  logic [XLEN-1:0] i_upd_pred_tgt,
  output logic            mispredict,
  output logic            flush_D,
  output logic            flush_E,
  output logic [XLEN-1:0] o_redirect_pc
`ifdef BP_PERF_EN
  ,
  output logic [PERF_W-1:0] o_lookups,
  output logic [PERF_W-1:0] o_mispredicts
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_jmp;
  logic [1:0]       e_cnt [DEPTH];
  logic [TAG_W-1:0] e_tag [DEPTH];
  logic [XLEN-1:0]  e_tgt [DEPTH];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  // F-stage lookup reads the pre-edge table; there is no update bypass.
  assign f_idx      = pc[IDX_W+1:2];
  assign f_tag      = pc[XLEN-1:IDX_W+2];
  assign f_hit      = e_valid[f_idx] && (e_tag[f_idx] == f_tag);
  assign prediction = f_hit && (e_jmp[f_idx] || e_cnt[f_idx][1]);
  assign PCTargetF  = prediction ? e_tgt[f_idx] : pc + XLEN'(4);

  logic             u_taken;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_wr_cnt;
  logic             u_wr_tgt;
  logic             u_alloc;
  logic [1:0]       u_cnt_cur;
  logic [1:0]       u_cnt_nxt;

  // Jumps are always taken regardless of how the E stage drives i_upd_taken.
  assign u_taken       = i_upd_taken || i_upd_is_jump;
  assign mispredict    = i_upd_vld && ((u_taken != i_upd_pred) ||
                         (u_taken && (i_upd_target != i_upd_pred_tgt)));
  assign flush_D       = mispredict;
  assign flush_E       = mispredict;
  assign o_redirect_pc = u_taken ? i_upd_target : i_upd_pc + XLEN'(4);

  assign u_idx     = i_upd_pc[IDX_W+1:2];
  assign u_tag     = i_upd_pc[XLEN-1:IDX_W+2];
  assign u_hit     = e_valid[u_idx] && (e_tag[u_idx] == u_tag);
  assign u_cnt_cur = e_cnt[u_idx];
  assign u_alloc   = i_upd_vld && !u_hit && u_taken;
  assign u_wr_cnt  = i_upd_vld && (u_hit || u_taken);
  assign u_wr_tgt  = i_upd_vld && u_taken;

  always_comb begin
    u_cnt_nxt = u_cnt_cur;
    if (!u_hit) begin
      u_cnt_nxt = i_upd_is_jump ? 2'b11 : CNT_INIT;
    end else if (i_upd_is_jump) begin
      u_cnt_nxt = 2'b11;
    end else if (u_taken) begin
      u_cnt_nxt = (u_cnt_cur == 2'b11) ? 2'b11 : u_cnt_cur + 2'b01;
    end else begin
      u_cnt_nxt = (u_cnt_cur == 2'b00) ? 2'b00 : u_cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      e_valid <= '0;
      e_jmp   <= '0;
      for (int i = 0; i < DEPTH; i++) e_cnt[i] <= 2'b01;
    end else begin
      if (u_wr_cnt) e_cnt[u_idx] <= u_cnt_nxt;
      if (u_alloc) begin
        e_valid[u_idx] <= 1'b1;
        e_jmp[u_idx]   <= i_upd_is_jump;
      end
    end
  end

  // Tag and target need no reset: they are only observed behind a valid bit.
  always_ff @(posedge i_clk) begin
    if (u_alloc) e_tag[u_idx] <= u_tag;
    if (u_wr_tgt) e_tgt[u_idx] <= i_upd_target;
  end

`ifdef BP_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_lookups     <= '0;
      o_mispredicts <= '0;
    end else begin
      o_lookups <= o_lookups + PERF_W'(1);
      if (mispredict) o_mispredicts <= o_mispredicts + PERF_W'(1);
    end
  end
`else
  // Perf counters not built; prediction path is unchanged.
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed vector table, reset corner cases,
// then random traffic checked against a table-of-records model.
module tb_branch_predictor_btb;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] pc;
  logic        prediction;
  logic [31:0] PCTargetF;
  logic        i_upd_vld;
  logic [31:0] i_upd_pc;
  logic        i_upd_is_jump;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred;
  logic [31:0] i_upd_pred_tgt;
  logic        mispredict;
  logic        flush_D;
  logic        flush_E;
  logic [31:0] o_redirect_pc;
`ifdef BP_PERF_EN
  logic [31:0] o_lookups;
  logic [31:0] o_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  branch_predictor_btb dut (
    .i_clk(i_clk), .i_rst(i_rst), .pc(pc), .prediction(prediction),
    .PCTargetF(PCTargetF), .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc),
    .i_upd_is_jump(i_upd_is_jump), .i_upd_taken(i_upd_taken),
    .i_upd_target(i_upd_target), .i_upd_pred(i_upd_pred),
    .i_upd_pred_tgt(i_upd_pred_tgt), .mispredict(mispredict),
    .flush_D(flush_D), .flush_E(flush_E), .o_redirect_pc(o_redirect_pc)
`ifdef BP_PERF_EN
    , .o_lookups(o_lookups), .o_mispredicts(o_mispredicts)
`endif
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // expected mispredict of the inputs currently driven; feeds the perf model
  logic m_misp = 1'b0;
  int   exp_lk;
  int   exp_mc;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      exp_lk <= 0;
      exp_mc <= 0;
    end else begin
      exp_lk <= exp_lk + 1;
      if (m_misp) exp_mc <= exp_mc + 1;
    end
  end

  // reference model: one record per BTB slot
  typedef struct {
    logic        v;
    logic [31:0] tag;
    logic [31:0] tgt;
    int          cnt;
    logic        jmp;
  } ent_t;
  ent_t mdl [64];

  function automatic void m_clear();
    for (int i = 0; i < 64; i++) begin
      mdl[i].v = 1'b0; mdl[i].tag = 0; mdl[i].tgt = 0; mdl[i].cnt = 1; mdl[i].jmp = 1'b0;
    end
  endfunction

  function automatic void m_lookup(input logic [31:0] a, output logic p, output logic [31:0] t);
    int k;
    k = int'((a >> 2) % 64);
    p = mdl[k].v && (mdl[k].tag == (a >> 8)) && (mdl[k].jmp || mdl[k].cnt >= 2);
    t = p ? mdl[k].tgt : a + 32'd4;
  endfunction

  function automatic void m_update(input logic [31:0] a, input logic j, input logic tk_in,
                                   input logic [31:0] tg);
    int   k;
    logic tk;
    logic hit;
    k   = int'((a >> 2) % 64);
    tk  = tk_in | j;
    hit = mdl[k].v && (mdl[k].tag == (a >> 8));
    if (hit) begin
      if (j) begin
        mdl[k].tgt = tg; mdl[k].cnt = 3;
      end else if (tk) begin
        mdl[k].tgt = tg; mdl[k].cnt = (mdl[k].cnt + 1 > 3) ? 3 : mdl[k].cnt + 1;
      end else begin
        mdl[k].cnt = (mdl[k].cnt - 1 < 0) ? 0 : mdl[k].cnt - 1;
      end
    end else if (tk) begin
      mdl[k].v = 1'b1; mdl[k].tag = a >> 8; mdl[k].tgt = tg;
      mdl[k].cnt = j ? 3 : 2; mdl[k].jmp = j;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] a, input logic vld, input logic [31:0] upc,
                       input logic j, input logic tk, input logic [31:0] tg,
                       input logic pr, input logic [31:0] ptg);
    pc = a; i_upd_vld = vld; i_upd_pc = upc; i_upd_is_jump = j;
    i_upd_taken = tk; i_upd_target = tg; i_upd_pred = pr; i_upd_pred_tgt = ptg;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic [31:0] upd_pc;
    logic        jmp;
    logic        tkn;
    logic [31:0] tgt;
    logic        pred;
    logic [31:0] ptgt;
    logic        e_pred;
    logic [31:0] e_tgt;
    logic        e_misp;
    logic [31:0] e_redir;
  } vec_t;
  vec_t vecs [22];

  // scoreboard for the random phase: {pred, PCTargetF, mispredict, redirect}
  logic [65:0] exp_q [$];

  initial begin
    vecs[0]  = '{32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0};
    vecs[1]  = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80};
    vecs[2]  = '{32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0};
    vecs[3]  = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104};
    vecs[4]  = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h0};
    vecs[5]  = '{32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0};
    vecs[6]  = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80};
    vecs[7]  = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80};
    vecs[8]  = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0};
    vecs[9]  = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0};
    vecs[10] = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104};
    vecs[11] = '{32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0};
    vecs[12] = '{32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h90,  1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h90};
    vecs[13] = '{32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h90,  1'b0, 32'h0};
    vecs[14] = '{32'h104, 1'b1, 32'h104, 1'b1, 1'b1, 32'h400, 1'b0, 32'h108, 1'b0, 32'h108, 1'b1, 32'h400};
    vecs[15] = '{32'h104, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h0};
    vecs[16] = '{32'h104, 1'b1, 32'h204, 1'b0, 1'b1, 32'h500, 1'b0, 32'h208, 1'b1, 32'h400, 1'b1, 32'h500};
    vecs[17] = '{32'h104, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h108, 1'b0, 32'h0};
    vecs[18] = '{32'h204, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h500, 1'b0, 32'h0};
    vecs[19] = '{32'h108, 1'b1, 32'h108, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10c, 1'b0, 32'h10c, 1'b0, 32'h0};
    vecs[20] = '{32'h108, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h10c, 1'b0, 32'h0};
    vecs[21] = '{32'h100, 1'b0, 32'h100, 1'b0, 1'b1, 32'h80,  1'b0, 32'h104, 1'b1, 32'h90,  1'b0, 32'h0};

    // reset state: outputs follow inputs while reset is held
    i_rst = 1'b1;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    check("rst_pred", {31'b0, prediction}, 32'h0);
    check("rst_tgtf", PCTargetF, 32'h104);
    check("rst_misp", {31'b0, mispredict}, 32'h0);
    next_cycle();
    i_rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].pc, vecs[i].vld, vecs[i].upd_pc, vecs[i].jmp, vecs[i].tkn,
            vecs[i].tgt, vecs[i].pred, vecs[i].ptgt);
      m_misp = vecs[i].e_misp;
      #2;
      check($sformatf("v%0d_pred", i), {31'b0, prediction}, {31'b0, vecs[i].e_pred});
      check($sformatf("v%0d_tgtf", i), PCTargetF, vecs[i].e_tgt);
      check($sformatf("v%0d_misp", i), {31'b0, mispredict}, {31'b0, vecs[i].e_misp});
      check($sformatf("v%0d_flush", i), {30'b0, flush_D, flush_E}, {30'b0, vecs[i].e_misp, vecs[i].e_misp});
      if (vecs[i].e_misp) check($sformatf("v%0d_redir", i), o_redirect_pc, vecs[i].e_redir);
      next_cycle();
    end

    // async reset between edges clears the table at once; update on that edge is dropped
    drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    m_misp = 1'b0;
    #2;
    check("pre_rst_pred", {31'b0, prediction}, 32'h1);
    drive(32'h100, 1'b1, 32'h108, 1'b0, 1'b1, 32'h700, 1'b1, 32'h700);
    #1;
    i_rst = 1'b1;
    #1;
    check("mid_rst_pred", {31'b0, prediction}, 32'h0);
    check("mid_rst_tgtf", PCTargetF, 32'h104);
    next_cycle();
    i_rst = 1'b0;
    drive(32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    check("rst_drop_upd", {31'b0, prediction}, 32'h0);
    check("rst_drop_tgtf", PCTargetF, 32'h10c);
    next_cycle();

    // random traffic against the model
    i_rst = 1'b1;
    m_clear();
    next_cycle();
    i_rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, ua, tg, mt, pt, rd;
      logic        vld, j, tk, mp, pr, ep, em;
      a   = ($urandom_range(1, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      ua  = ($urandom_range(1, 3) << 8) | ($urandom_range(0, 7) << 2);
      vld = ($urandom_range(0, 9) < 7);
      j   = ($urandom_range(0, 4) == 0);
      tk  = j ? 1'b1 : 1'($urandom_range(0, 1));
      tg  = 32'h1000 + ($urandom_range(0, 3) << 4);
      m_lookup(ua, mp, mt);
      pr  = ($urandom_range(0, 3) != 0) ? mp : 1'($urandom_range(0, 1));
      pt  = ($urandom_range(0, 3) != 0) ? mt : 32'h1000 + ($urandom_range(0, 3) << 4);
      drive(a, vld, ua, j, tk, tg, pr, pt);
      m_lookup(a, ep, mt);
      em = vld && ((tk != pr) || (tk && (tg != pt)));
      rd = tk ? tg : ua + 32'd4;
      m_misp = em;
      exp_q.push_back({ep, mt, em, rd});
      #2;
      begin
        logic [65:0] e;
        e = exp_q.pop_front();
        check("rnd_pred", {31'b0, prediction}, {31'b0, e[65]});
        check("rnd_tgtf", PCTargetF, e[64:33]);
        check("rnd_misp", {30'b0, flush_D, mispredict}, {30'b0, e[32], e[32]});
        if (e[32]) check("rnd_redir", o_redirect_pc, e[31:0]);
      end
      next_cycle();
      if (vld) m_update(ua, j, tk, tg);
    end

`ifdef BP_PERF_EN
    check("perf_lookups", o_lookups, exp_lk);
    check("perf_mispredicts", o_mispredicts, exp_mc);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
